// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory bank: access size and FSM
// state encodings, byte-enable mask and load extension functions.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  // Mask is built for the widest word (8 lanes); narrower banks keep the low bits.
  function automatic logic [7:0] byte_en(size_e sz, logic [2:0] lane);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

  function automatic logic [63:0] load_ext(logic [63:0] raw, size_e sz, logic uns);
    logic [63:0] r;
    case (sz)
      SZ_B:    r = uns ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    r = uns ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    r = uns ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// Request/response bus of the data memory bank (valid/ready request,
// one-cycle registered response).
interface data_memory_bank_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data shift and byte enables,
// load extract and sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int BYTES  = DATA_W / 8,
  localparam int LANE_W = $clog2(BYTES)
) (
  input  logic [LANE_W-1:0] lane,
  input  size_e             size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [BYTES-1:0]  be,
  output logic [DATA_W-1:0] rdata
);
  logic [7:0]        be8;
  logic [DATA_W-1:0] raw;
  logic [63:0]       ext;

  always_comb begin
    be8      = byte_en(size, 3'(lane));
    be       = be8[BYTES-1:0];
    wdata_sh = wdata << {lane, 3'b000};
    raw      = rword >> {lane, 3'b000};
    ext      = load_ext(64'(raw), size, uns);
    rdata    = ext[DATA_W-1:0];
  end
endmodule

// File: rtl/data_memory_bank.sv
// Parametrised byte-addressable little-endian data memory with sized
// loads/stores, registered response and post-reset clear. Optional
// debug read tap under DMEM_DEBUG_TAP_EN.
module data_memory_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int DEPTH_BYTES    = 256,
  parameter int ADDR_W         = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset_n,
  data_memory_bank_if.slave bus
`ifdef DMEM_DEBUG_TAP_EN
  ,
  input  logic [$clog2(DEPTH_BYTES/(DATA_W/8))-1:0] dbg_addr,
  output logic [DATA_W-1:0]                         dbg_data
`endif
);
  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int WORDS  = DEPTH_BYTES / BYTES;
  localparam int IDX_W  = $clog2(WORDS);

  logic [DATA_W-1:0] mem [WORDS];

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic              rsp_vld_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  size_e             size;
  logic [2:0]        amask;
  logic              accept, err, wr_en;
  logic [DATA_W-1:0] wdata_sh, rdata;
  logic [BYTES-1:0]  be;

  assign idx    = bus.req_addr[IDX_W+LANE_W-1:LANE_W];
  assign lane   = bus.req_addr[LANE_W-1:0];
  assign size   = size_e'(bus.req_size);
  assign amask  = 3'((4'd1 << bus.req_size) - 4'd1);
  assign accept = bus.req_valid && rdy_q;
  assign err    = (bus.req_addr >= ADDR_W'(DEPTH_BYTES))
               || (|(bus.req_addr[2:0] & amask))
               || ((DATA_W == 32) && (size == SZ_D));
  assign wr_en  = accept && bus.req_write && !err;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .lane     (lane),
    .size     (size),
    .uns      (bus.req_unsigned),
    .wdata    (bus.req_wdata),
    .rword    (mem[idx]),
    .wdata_sh (wdata_sh),
    .be       (be),
    .rdata    (rdata)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      ST_INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(WORDS - 1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
    // ready is registered so it reads 0 throughout reset regardless of state
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      rdy_q      <= 1'b0;
      clr_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      clr_q      <= clr_d;
      rsp_vld_q  <= accept;
      rsp_err_q  <= accept && err;
      rsp_data_q <= (accept && !bus.req_write && !err) ? rdata : '0;
    end
  end

  // Storage has no reset; the reset sensitivity only blocks writes while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n) begin
      if (state_q == ST_INIT) begin
        mem[clr_q] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < BYTES; b++)
          if (be[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_data_q;

`ifdef DMEM_DEBUG_TAP_EN
  assign dbg_data = mem[dbg_addr];
`endif
endmodule
